// File: rtl/seg_pkg.sv
// Shared 7-segment definitions: segment constants,
// hex-to-segment decode and commit FSM states.
package seg_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [6:0] SEG_BTM = 7'b0100011;
  localparam logic [6:0] SEG_TOP = 7'b0011100;

  typedef enum logic [1:0] {
    IDLE,
    PEND,
    COPY
  } commit_st_e;

  // Active-low {g,f,e,d,c,b,a} pattern for one hex digit.
  function automatic logic [6:0] hex2seg(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg_prescaler.sv
// Free-running N-bit slot prescaler.
// Ports: clk, rst_n in; slot_tick_o (count at max), count_o out.
module seg_prescaler #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  output logic         slot_tick_o,
  output logic [N-1:0] count_o
);

  logic [N-1:0] cnt_q;
  logic [N-1:0] cnt_d;

  assign cnt_d = cnt_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign count_o     = cnt_q;
  assign slot_tick_o = &cnt_q;

endmodule

// File: rtl/seg_scan_mux8.sv
// 8-digit 7-segment scan mux with shadow/active banks.
// Ports: clk, rst_n, wr_en/wr_addr/wr_data, commit in;
//        commit_pend, frame_done, CA, DP, AN out.
module seg_scan_mux8
  import seg_pkg::*;
#(
  parameter int N         = 16,
  parameter int BLANK_CYC = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic [2:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic       commit,
  output logic       commit_pend,
  output logic       frame_done,
  output logic [6:0] CA,
  output logic       DP,
  output logic [7:0] AN
);

  localparam logic [N-1:0] BLANK_W = BLANK_CYC[N-1:0];

  logic         slot_tick;
  logic [N-1:0] count;
  logic [2:0]   digit_q;
  logic         frame_bnd;

  logic [7:0]   shadow_q [8];
  logic [7:0]   active_q [8];

  commit_st_e   state_q;
  commit_st_e   state_d;
  logic         pend_q;
  logic         fdone_q;

  logic [7:0]   an_q;
  logic [7:0]   an_d;
  logic [7:0]   seg_q;
  logic [7:0]   seg_d;

  seg_prescaler #(.N(N)) u_pre (
    .clk        (clk),
    .rst_n      (rst_n),
    .slot_tick_o(slot_tick),
    .count_o    (count)
  );

  assign frame_bnd = slot_tick & (digit_q == 3'd7);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         digit_q <= '0;
    else if (slot_tick) digit_q <= digit_q + 3'd1;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (commit)    state_d = PEND;
      PEND:    if (frame_bnd) state_d = COPY;
      COPY:                   state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pend_q  <= 1'b0;
      fdone_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= (state_d != IDLE);
      fdone_q <= frame_bnd;
    end
  end

  // COPY is the first cycle of slot 0, still inside the
  // blanking window, so a frame never shows mixed banks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        shadow_q[i] <= 8'hFF;
        active_q[i] <= 8'hFF;
      end
    end else begin
      if (wr_en) shadow_q[wr_addr] <= wr_data;
      if (state_q == COPY) begin
        for (int i = 0; i < 8; i++) active_q[i] <= shadow_q[i];
      end
    end
  end

  always_comb begin
    an_d  = 8'hFF;
    seg_d = {1'b1, SEG_OFF};
    if (count >= BLANK_W) begin
      an_d  = ~(8'h80 >> digit_q);
      seg_d = active_q[digit_q];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_q  <= 8'hFF;
      seg_q <= {1'b1, SEG_OFF};
    end else begin
      an_q  <= an_d;
      seg_q <= seg_d;
    end
  end

  assign AN          = an_q;
  assign CA          = seg_q[6:0];
  assign DP          = seg_q[7];
  assign commit_pend = pend_q;
  assign frame_done  = fdone_q;

endmodule

// File: tb/tb_seg_scan_mux8.sv
// Directed bench for seg_scan_mux8 (N=4, BLANK_CYC=2)
// with a queue of pending bank copies as scoreboard.
module tb_seg_scan_mux8;

  localparam int N     = 4;
  localparam int BC    = 2;
  localparam int SLOT  = 16;
  localparam int FRAME = 128;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [7:0] wr_data;
  logic       commit;
  logic       commit_pend;
  logic       frame_done;
  logic [6:0] CA;
  logic       DP;
  logic [7:0] AN;

  int checks = 0;
  int errors = 0;
  int k = 0;

  logic [7:0] sh_m  [8];
  logic [7:0] act_m [8];
  int         copy_q[$];

  seg_scan_mux8 #(.N(N), .BLANK_CYC(BC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .commit     (commit),
    .commit_pend(commit_pend),
    .frame_done (frame_done),
    .CA         (CA),
    .DP         (DP),
    .AN         (AN)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s k=%0d observed=%0h expected=%0h",
             tag, k, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 8; i++) begin
      sh_m[i]  = 8'hFF;
      act_m[i] = 8'hFF;
    end
    copy_q.delete();
    k = 0;
  endtask

  task automatic apply_reset();
    #3 rst_n = 1'b0;
    #1;
    chk("RST_AN", AN, 8'hFF);
    chk("RST_SEG", {DP, CA}, 8'hFF);
    chk("RST_PEND", commit_pend, 1'b0);
    chk("RST_FDONE", frame_done, 1'b0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    model_clear();
  endtask

  // One clock: drive inputs, advance the model, check pins.
  task automatic tick(input logic       we,
                      input logic [2:0] a,
                      input logic [7:0] d,
                      input logic       cm);
    logic [7:0] ea;
    logic [7:0] es;
    logic       efd;
    logic       ep;
    int         p;
    int         cnt;
    int         dig;
    wr_en   = we;
    wr_addr = a;
    wr_data = d;
    commit  = cm;
    @(posedge clk);
    k++;
    p   = k - 1;
    cnt = p % SLOT;
    dig = (p / SLOT) % 8;
    ea  = 8'hFF;
    es  = 8'hFF;
    if (cnt >= BC) begin
      ea[7-dig] = 1'b0;
      es = act_m[dig];
    end
    efd = (k % FRAME == 0);
    if (cm && copy_q.size() == 0)
      copy_q.push_back((k / FRAME + 1) * FRAME + 1);
    if (copy_q.size() != 0 && copy_q[0] == k) begin
      act_m = sh_m;
      void'(copy_q.pop_front());
    end
    if (we) sh_m[a] = d;
    ep = (copy_q.size() != 0);
    #1;
    chk("AN", AN, ea);
    chk("SEG", {DP, CA}, es);
    chk("FRAME_DONE", frame_done, efd);
    chk("PEND", commit_pend, ep);
    chk("AN_ONEHOT", ($countones(~AN) <= 1), 1'b1);
    wr_en  = 1'b0;
    commit = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b0, 3'd0, 8'h00, 1'b0);
  endtask

  initial begin
    int e;
    rst_n   = 1'b1;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    commit  = 1'b0;
    model_clear();

    apply_reset();
    idle(20);

    for (int i = 0; i < 8; i++)
      tick(1'b1, 3'(i), 8'h80 | 8'(i), i == 7);
    idle(2 * FRAME);

    for (int i = 0; i < 8; i++)
      tick(1'b1, 3'(i), 8'h40 | 8'(i + 8), 1'b0);
    idle(10);
    tick(1'b0, 3'd0, 8'h00, 1'b1);
    idle(2 * FRAME);

    tick(1'b1, 3'd5, 8'h12, 1'b0);
    while ((k + 1) % FRAME != 0) idle(1);
    tick(1'b0, 3'd0, 8'h00, 1'b1);
    idle(30);
    tick(1'b0, 3'd0, 8'h00, 1'b1);
    idle(2 * FRAME + 10);

    idle(40);
    tick(1'b1, 3'd3, 8'h00, 1'b1);
    e = copy_q[0];
    while (k < e - 1) idle(1);
    tick(1'b1, 3'd3, 8'hFF, 1'b0);
    idle(FRAME + 20);
    tick(1'b0, 3'd0, 8'h00, 1'b1);
    idle(2 * FRAME);

    tick(1'b1, 3'd0, 8'h00, 1'b0);
    tick(1'b0, 3'd0, 8'h00, 1'b1);
    idle(40);
    apply_reset();
    idle(2 * FRAME);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
